// File: rtl/exgcd_pkg.sv
// Shared definitions for the extended-GCD datapath and its downstream stages.
// Holds the default operand width and the mod_div control-state encoding.
package exgcd_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mod_mul_step.sv
// One step of an MSB-first interleaved modular multiplier:
// acc_o = (2*acc_i + (bit_i ? x_i : 0)) mod m_i, assuming acc_i < m_i and x_i < m_i.
module mod_mul_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   acc_o
);

    logic [WIDTH:0] mExt;
    logic [WIDTH:0] dbl;
    logic [WIDTH:0] dblRed;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] sumRed;

    // Both operands stay below m, so a single conditional subtract after
    // the doubling and after the add keeps the accumulator reduced.
    always_comb begin
        mExt   = {1'b0, m_i};
        dbl    = acc_i << 1;
        dblRed = (dbl >= mExt) ? (dbl - mExt) : dbl;
        sum    = dblRed + {1'b0, x_i};
        sumRed = (sum >= mExt) ? (sum - mExt) : sum;
        acc_o  = bit_i ? sumRed : dblRed;
    end

endmodule

// File: rtl/mod_div.sv
// Modular division q = (c * inv) mod m, bit-serial over WIDTH cycles.
// Define MOD_DIV_INV_CHECK_EN to also verify (a * inv) mod m == 1 in parallel.
module mod_div
    import exgcd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH-1:0] in_gcd,
    input  logic [WIDTH-1:0] in_inv,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic             out_err,
    output logic             out_chk_fail
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] inv_q, inv_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             err_q, err_d;
    logic [WIDTH:0]   stepAcc;
    logic             inputBad;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_q     = q_q;
    assign out_err   = err_q;
    assign inputBad  = (in_m == '0) || (in_gcd != WIDTH'(1)) || (in_inv >= in_m);

    mod_mul_step #(.WIDTH(WIDTH)) u_qStep (
        .acc_i (acc_q),
        .x_i   (inv_q),
        .bit_i (c_q[cnt_q]),
        .m_i   (m_q),
        .acc_o (stepAcc)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        inv_d   = inv_q;
        c_d     = c_q;
        q_d     = q_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d   = in_m;
                    inv_d = in_inv;
                    c_d   = in_c;
                    acc_d = '0;
                    cnt_d = CW'(WIDTH - 1);
                    if (inputBad) begin
                        err_d   = 1'b1;
                        q_d     = '0;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                acc_d = stepAcc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    q_d     = stepAcc[WIDTH-1:0];
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            m_q     <= '0;
            inv_q   <= '0;
            c_q     <= '0;
            q_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            inv_q   <= inv_d;
            c_q     <= c_d;
            q_q     <= q_d;
            err_q   <= err_d;
        end
    end

`ifdef MOD_DIV_INV_CHECK_EN
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH:0]   chkAcc_q, chkAcc_d;
    logic [WIDTH:0]   chkStep;
    logic             chk_q, chk_d;

    // Runs in lockstep with the quotient path, scanning a instead of c.
    mod_mul_step #(.WIDTH(WIDTH)) u_chkStep (
        .acc_i (chkAcc_q),
        .x_i   (inv_q),
        .bit_i (a_q[cnt_q]),
        .m_i   (m_q),
        .acc_o (chkStep)
    );

    always_comb begin
        a_d      = a_q;
        chkAcc_d = chkAcc_q;
        chk_d    = chk_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    chkAcc_d = '0;
                    chk_d    = 1'b0;
                end
            end
            MUL: begin
                chkAcc_d = chkStep;
                if (cnt_q == '0) begin
                    chk_d = (chkStep != {{WIDTH{1'b0}}, 1'b1});
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            chkAcc_q <= '0;
            chk_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            chkAcc_q <= chkAcc_d;
            chk_q    <= chk_d;
        end
    end

    assign out_chk_fail = chk_q;
`else
    logic unusedA;

    assign unusedA      = ^in_a;
    assign out_chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_mod_div.sv
// Directed self-checking bench for mod_div (WIDTH=8) with hand-computed results.
// Expected chk_fail values follow MOD_DIV_INV_CHECK_EN when it is defined.
module tb_mod_div;

    localparam int W = 8;
`ifdef MOD_DIV_INV_CHECK_EN
    localparam logic CHK_ON = 1'b1;
`else
    localparam logic CHK_ON = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_m;
    logic [W-1:0] in_gcd;
    logic [W-1:0] in_inv;
    logic [W-1:0] in_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_q;
    logic         out_err;
    logic         out_chk_fail;

    int nVectors = 0;
    int nMiscompares = 0;

    mod_div #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_m         (in_m),
        .in_gcd       (in_gcd),
        .in_inv       (in_inv),
        .in_c         (in_c),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_q        (out_q),
        .out_err      (out_err),
        .out_chk_fail (out_chk_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Presents one input set and returns right after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] m, input logic [W-1:0] g,
                                 input logic [W-1:0] inv, input logic [W-1:0] c);
        int waitCycles;
        @(negedge clk);
        in_a = a; in_m = m; in_gcd = g; in_inv = inv; in_c = c;
        in_valid = 1'b1;
        waitCycles = 0;
        while (!in_ready && waitCycles < 40) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Latency is counted in edges after the accepting edge until out_valid is seen.
    task automatic waitResult(input string tag, input int expLat);
        int lat;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    endtask

    task automatic runVector(input string tag, input logic [W-1:0] a, input logic [W-1:0] m,
                             input logic [W-1:0] g, input logic [W-1:0] inv, input logic [W-1:0] c,
                             input logic [W-1:0] expQ, input logic expErr, input logic expChk);
        applyStimulus(a, m, g, inv, c);
        waitResult(tag, expErr ? 0 : W);
        checkOutput({tag, "_q"}, 32'(out_q), 32'(expQ));
        checkOutput({tag, "_err"}, 32'(out_err), 32'(expErr));
        checkOutput({tag, "_chk"}, 32'(out_chk_fail), 32'(expChk));
        @(negedge clk);
        checkOutput({tag, "_release"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_m = '0; in_gcd = '0; in_inv = '0; in_c = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", 32'({out_valid, out_err, out_chk_fail, out_q}), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        runVector("basic",    8'd3, 8'd7,   8'd1, 8'd5,   8'd4,   8'd6,   1'b0, 1'b0);
        runVector("fullwidth", 8'd2, 8'd251, 8'd1, 8'd126, 8'd250, 8'd125, 1'b0, 1'b0);
        runVector("c_max",    8'd2, 8'd251, 8'd1, 8'd126, 8'd255, 8'd2,   1'b0, 1'b0);
        runVector("m13",      8'd5, 8'd13,  8'd1, 8'd8,   8'd12,  8'd5,   1'b0, 1'b0);
        runVector("c_zero",   8'd3, 8'd7,   8'd1, 8'd5,   8'd0,   8'd0,   1'b0, 1'b0);
        runVector("m_one",    8'd5, 8'd1,   8'd1, 8'd0,   8'd5,   8'd0,   1'b0, CHK_ON);
        runVector("err_gcd",  8'd4, 8'd6,   8'd2, 8'd0,   8'd1,   8'd0,   1'b1, 1'b0);
        runVector("err_m0",   8'd3, 8'd0,   8'd1, 8'd0,   8'd5,   8'd0,   1'b1, 1'b0);
        runVector("err_inv",  8'd3, 8'd7,   8'd1, 8'd7,   8'd5,   8'd0,   1'b1, 1'b0);
        runVector("chk_bad",  8'd3, 8'd7,   8'd1, 8'd4,   8'd1,   8'd4,   1'b0, CHK_ON);

        // Backpressure: result must stay frozen while the consumer stalls.
        out_ready = 1'b0;
        applyStimulus(8'd3, 8'd7, 8'd1, 8'd5, 8'd4);
        waitResult("hold", W);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_valid_ready", 32'({out_valid, in_ready}), 32'b10);
            checkOutput("hold_q", 32'(out_q), 32'd6);
            checkOutput("hold_flags", 32'({out_err, out_chk_fail}), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("hold_release", 32'({out_valid, in_ready}), 32'b01);

        // Reset during the multiply discards the operation.
        applyStimulus(8'd2, 8'd251, 8'd1, 8'd126, 8'd250);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_outputs", 32'({out_valid, out_err, out_chk_fail, out_q}), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        runVector("after_rst", 8'd3, 8'd7, 8'd1, 8'd5, 8'd4, 8'd6, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
